// File: rtl/ifetch_ctrl_pkg.sv
// Shared CPU definitions for the instruction fetch slice: widths, constants
// and the {pc, instr} entry type buffered between fetch and decode.
package ifetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned, so the low two address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus: instruction memory port, redirect input and decode handshake.
interface ifetch_ctrl_if;
  import ifetch_ctrl_pkg::*;

  logic [XLEN-1:0] iaddr;
  logic [XLEN-1:0] idata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            fetch_stall;

  modport master (
    output iaddr, out_valid, out_pc, out_instr, fetch_stall,
    input  idata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  iaddr, out_valid, out_pc, out_instr, fetch_stall,
    output idata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/ifetch_ctrl_fetch_fifo.sv
// Generic DEPTH x 64-bit synchronous FIFO with flush. Pop while full lets a
// push land in the same cycle; flush overrides both push and pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [63:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign empty_o = (count_q == {(AW+1){1'b0}});
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(do_push_s);
      rd_ptr_d = rd_ptr_q + AW'(do_pop_s);
      count_d  = count_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end

  // State registers and storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 64'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, pushes {pc, instr} pairs
// into a small FIFO for decode and restarts fetch on redirects.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  ifetch_ctrl_if.master fetch_if
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pop_s, push_s, full_s, empty_s;
  fetch_entry_t    wentry_s, rentry_s;

  assign pop_s    = ~empty_s & fetch_if.out_ready;
  assign push_s   = ~fetch_if.redirect_valid & (~full_s | pop_s);
  assign wentry_s = '{pc: pc_q, instr: fetch_if.idata};

  // Fetch PC: a redirect wins over sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (fetch_if.redirect_valid) begin
      pc_d = align_pc(fetch_if.redirect_pc);
    end else if (push_s) begin
      pc_d = pc_q + INSTR_BYTES;
    end else begin
      pc_d = pc_q;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (fetch_if.redirect_valid),
    .wdata_i (wentry_s),
    .rdata_o (rentry_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign fetch_if.iaddr       = pc_q;
  assign fetch_if.out_valid   = ~empty_s;
  assign fetch_if.out_pc      = empty_s ? 32'd0 : rentry_s.pc;
  assign fetch_if.out_instr   = empty_s ? 32'd0 : rentry_s.instr;
  assign fetch_if.fetch_stall = full_s & ~pop_s;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed self-checking bench for ifetch_ctrl; instruction memory word k
// holds 32'h1000_0000 + k.
module tb_ifetch_ctrl;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  ifetch_ctrl_if bus ();

  ifetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetch_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.idata = 32'h1000_0000 + {2'b00, bus.iaddr[31:2]};

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'h1000_0000 + {2'b00, pc[31:2]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic do_reset(input logic ready);
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.out_ready = ready;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_stall", {31'd0, bus.fetch_stall}, 32'd0);
    chk("reset_iaddr", bus.iaddr, 32'h0000_0000);
    chk("reset_out_pc", bus.out_pc, 32'd0);
    chk("reset_out_instr", bus.out_instr, 32'd0);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 16; i++) begin
      tick();
      #1;
      chk("stream_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stream_pc", bus.out_pc, 32'(4 * i));
      chk("stream_instr", bus.out_instr, 32'h1000_0000 + 32'(i));
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    tick();
    #1;
    chk("bp_first_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_first_stall", {31'd0, bus.fetch_stall}, 32'd0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      #1;
      chk("bp_stall", {31'd0, bus.fetch_stall}, 32'd1);
      chk("bp_iaddr_hold", bus.iaddr, 32'h8);
      chk("bp_pc_hold", bus.out_pc, 32'h0);
    end
    tick();
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_pc", bus.out_pc, 32'h0);
    chk("bp_release_stall", {31'd0, bus.fetch_stall}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      #1;
      chk("bp_drain_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_drain_pc", bus.out_pc, 32'(4 * k));
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    tick();
    tick();
    #1;
    chk("rd_full_stall", {31'd0, bus.fetch_stall}, 32'd1);
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    #1;
    chk("rd_head_consumed", bus.out_pc, 32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("rd_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rd_new_iaddr", bus.iaddr, 32'h0000_0100);
    tick();
    #1;
    chk("rd_first_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("rd_first_pc", bus.out_pc, 32'h0000_0100);
    chk("rd_first_instr", bus.out_instr, exp_instr(32'h100));
    tick();
    #1;
    chk("rd_second_pc", bus.out_pc, 32'h0000_0104);
  endtask

  task automatic test_back_to_back();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    tick();
    bus.redirect_pc = 32'h0000_0300;
    #1;
    chk("b2b_mid_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("b2b_mid_iaddr", bus.iaddr, 32'h0000_0200);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("b2b_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("b2b_iaddr", bus.iaddr, 32'h0000_0300);
    tick();
    #1;
    chk("b2b_first_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("b2b_first_pc", bus.out_pc, 32'h0000_0300);
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("wrap_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("wrap_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("wrap_pc", bus.out_pc, exp_pc);
      chk("wrap_instr", bus.out_instr, exp_instr(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("rm_full_stall", {31'd0, bus.fetch_stall}, 32'd1);
    rst_n = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0500;
    tick();
    bus.redirect_valid = 1'b0;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("rm_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rm_stall", {31'd0, bus.fetch_stall}, 32'd0);
    chk("rm_iaddr", bus.iaddr, 32'h0000_0000);
    tick();
    #1;
    chk("rm_first_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("rm_first_pc", bus.out_pc, 32'h0000_0000);
    chk("rm_first_instr", bus.out_instr, 32'h1000_0000);
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
